// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin actuated phase scheduler for two vehicle groups and a pedestrian crossing
module traffic_phase_scheduler #(
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 10,
    parameter int EXT_TIME    = 3,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int WALK_TIME   = 5,
    parameter int TIMER_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Traffic,
    input  logic       Ped_req,
    output logic [3:0] Red,
    output logic [3:0] Yellow,
    output logic [3:0] Green,
    output logic       Walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, G13 = 3'd1, Y13 = 3'd2, G24 = 3'd3, Y24 = 3'd4, PED = 3'd5, AR = 3'd6
    } state_t;
    typedef enum logic [1:0] {L13 = 2'd0, L24 = 2'd1, LP = 2'd2} grp_t;
    localparam logic [TIMER_W:0] EXT_W  = (TIMER_W+1)'(EXT_TIME);
    localparam logic [TIMER_W:0] GMAX_W = (TIMER_W+1)'(GREEN_MAX);
    state_t state, nxt, win;
    grp_t last;
    logic [TIMER_W-1:0] timer, age, timer_nxt, age_nxt;
    logic req13, req24, reqp;
    logic t13, t24, pend13, pend24, pendp, tz, enter, ext, in_green;
    assign t13      = Traffic[0] | Traffic[2];
    assign t24      = Traffic[1] | Traffic[3];
    assign pend13   = req13 | t13;
    assign pend24   = req24 | t24;
    assign pendp    = reqp | Ped_req;
    assign tz       = timer == '0;
    assign enter    = nxt != state;
    assign in_green = state == G13 || state == G24;
    assign ext = (state == G13 ? t13 & ~(pend24 | pendp) : t24 & ~(pend13 | pendp))
               && ({1'b0, age} + EXT_W <= GMAX_W);
    function automatic logic [TIMER_W-1:0] load(input state_t s);
        case (s)
            G13, G24: load = TIMER_W'(GREEN_MIN - 1);
            Y13, Y24: load = TIMER_W'(YELLOW_TIME - 1);
            PED:      load = TIMER_W'(WALK_TIME - 1);
            AR:       load = TIMER_W'(ALLRED_TIME - 1);
            default:  load = '0;
        endcase
    endfunction
    // Search starts just after the group served last
    always_comb begin
        win = IDLE;
        case (last)
            L13:     win = pend24 ? G24 : pendp ? PED : pend13 ? G13 : IDLE;
            L24:     win = pendp ? PED : pend13 ? G13 : pend24 ? G24 : IDLE;
            default: win = pend13 ? G13 : pend24 ? G24 : pendp ? PED : IDLE;
        endcase
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:          nxt = win;
            G13:           nxt = tz && !ext ? Y13 : G13;
            G24:           nxt = tz && !ext ? Y24 : G24;
            Y13, Y24, PED: nxt = tz ? AR : state;
            AR:            nxt = tz ? win : AR;
            default:       nxt = IDLE;
        endcase
    end
    assign timer_nxt = enter ? load(nxt)
                     : tz ? (in_green ? TIMER_W'(EXT_TIME - 1) : '0)
                     : timer - TIMER_W'(1);
    assign age_nxt = (nxt == G13 || nxt == G24) ? (enter ? TIMER_W'(1) : age + TIMER_W'(1)) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            age   <= '0;
            req13 <= 1'b0;
            req24 <= 1'b0;
            reqp  <= 1'b0;
            last  <= LP;
        end else begin
            state <= nxt;
            timer <= timer_nxt;
            age   <= age_nxt;
            req13 <= (enter && nxt == G13) ? 1'b0 : (t13 && state != G13) ? 1'b1 : req13;
            req24 <= (enter && nxt == G24) ? 1'b0 : (t24 && state != G24) ? 1'b1 : req24;
            reqp  <= (enter && nxt == PED) ? 1'b0 : (Ped_req && state != PED) ? 1'b1 : reqp;
            last  <= !enter ? last : nxt == G13 ? L13 : nxt == G24 ? L24 : nxt == PED ? LP : last;
        end
    end
    assign Red    = (state == G13 || state == Y13) ? 4'b1010 : (state == G24 || state == Y24) ? 4'b0101 : 4'b1111;
    assign Yellow = state == Y13 ? 4'b0101 : state == Y24 ? 4'b1010 : 4'b0000;
    assign Green  = state == G13 ? 4'b0101 : state == G24 ? 4'b1010 : 4'b0000;
    assign Walk   = state == PED;
    assign phase  = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed bench with an elapsed/length phase model checked every cycle
module tb_traffic_phase_scheduler;
    localparam int GMIN = 4, GMAX = 10, EXT = 3, YEL = 2, ART = 1, WLK = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] traffic = 4'b0000;
    logic ped = 1'b0;
    logic [3:0] red, yellow, green;
    logic walk;
    logic [2:0] phase;
    int checks = 0, errors = 0;
    int m_ph = 0, m_el = 0, m_len = 1, m_last = 2;
    bit m_r13 = 1'b0, m_r24 = 1'b0, m_rp = 1'b0;
    int hist[60];
    int gl[$];
    int ord[4] = '{1, 3, 5, 1};
    int n;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .EXT_TIME(EXT), .YELLOW_TIME(YEL),
        .ALLRED_TIME(ART), .WALK_TIME(WLK), .TIMER_W(16)
    ) dut (
        .clk(clk), .rst(rst), .Traffic(traffic), .Ped_req(ped),
        .Red(red), .Yellow(yellow), .Green(green), .Walk(walk), .phase(phase)
    );

    function automatic int dur(input int ph);
        return (ph == 1 || ph == 3) ? GMIN : (ph == 2 || ph == 4) ? YEL : ph == 5 ? WLK : ph == 6 ? ART : 1;
    endfunction
    // groups: 0 = pair 1/3, 1 = pair 2/4, 2 = pedestrian; scan starts after the last served
    function automatic int pick(input int lst, input bit p13, input bit p24, input bit pp);
        bit pend[3];
        pend = '{p13, p24, pp};
        for (int i = 1; i <= 3; i++) if (pend[(lst + i) % 3]) return (lst + i) % 3;
        return -1;
    endfunction
    function automatic int gph(input int g);
        return g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 5 : 0;
    endfunction
    function automatic int exp_red(input int ph);
        return (ph == 1 || ph == 2) ? 10 : (ph == 3 || ph == 4) ? 5 : 15;
    endfunction
    function automatic int exp_yel(input int ph);
        return ph == 2 ? 5 : ph == 4 ? 10 : 0;
    endfunction
    function automatic int exp_grn(input int ph);
        return ph == 1 ? 5 : ph == 3 ? 10 : 0;
    endfunction

    // Advances the model by the clock edge about to happen, using the inputs now applied
    task automatic model_tick();
        bit t13, t24, p13, p24, pp, own, comp;
        int nph, nel, nlen, g;
        if (rst) begin
            m_ph = 0; m_el = 0; m_len = 1; m_last = 2;
            m_r13 = 1'b0; m_r24 = 1'b0; m_rp = 1'b0;
            return;
        end
        t13 = traffic[0] | traffic[2];
        t24 = traffic[1] | traffic[3];
        p13 = m_r13 | t13;
        p24 = m_r24 | t24;
        pp  = m_rp | ped;
        nph = m_ph; nel = m_el + 1; nlen = m_len;
        case (m_ph)
            0: begin g = pick(m_last, p13, p24, pp); nph = gph(g); end
            1, 3: if (m_el == m_len) begin
                own  = m_ph == 1 ? t13 : t24;
                comp = m_ph == 1 ? (p24 | pp) : (p13 | pp);
                if (own && !comp && m_len + EXT <= GMAX) nlen = m_len + EXT;
                else nph = m_ph + 1;
            end
            2, 4, 5: if (m_el == m_len) nph = 6;
            6: if (m_el == m_len) begin g = pick(m_last, p13, p24, pp); nph = gph(g); end
            default: nph = 0;
        endcase
        m_r13 = (nph == 1 && m_ph != 1) ? 1'b0 : (t13 && m_ph != 1) ? 1'b1 : m_r13;
        m_r24 = (nph == 3 && m_ph != 3) ? 1'b0 : (t24 && m_ph != 3) ? 1'b1 : m_r24;
        m_rp  = (nph == 5 && m_ph != 5) ? 1'b0 : (ped && m_ph != 5) ? 1'b1 : m_rp;
        if (nph != m_ph) begin
            nel = 1;
            nlen = dur(nph);
            if (nph == 1) m_last = 0;
            else if (nph == 3) m_last = 1;
            else if (nph == 5) m_last = 2;
        end
        m_ph = nph; m_el = nel; m_len = nlen;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_tick();
        @(negedge clk);
        chk("phase", int'(phase), m_ph);
        chk("red", int'(red), exp_red(m_ph));
        chk("yellow", int'(yellow), exp_yel(m_ph));
        chk("green", int'(green), exp_grn(m_ph));
        chk("walk", int'(walk), m_ph == 5 ? 1 : 0);
    endtask

    task automatic run_len(input int ph, output int cnt);
        cnt = 0;
        while (int'(phase) == ph && cnt < 50) begin
            cnt++;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_phase", int'(phase), 0);
        chk("rst_red", int'(red), 15);
        chk("rst_yellow", int'(yellow), 0);
        chk("rst_walk", int'(walk), 0);
        step();
        // single-cycle request from idle
        traffic = 4'b0001;
        step();
        chk("t1_k1", int'(phase), 1);
        traffic = 4'b0000;
        repeat (3) step();
        chk("t1_k4", int'(phase), 1);
        step();
        chk("t1_k5", int'(phase), 2);
        step();
        step();
        chk("t1_k7", int'(phase), 6);
        step();
        chk("t1_k8", int'(phase), 0);
        chk("t1_k8_red", int'(red), 15);
        // held traffic extends green to the maximum, then re-enters
        traffic = 4'b0001;
        step();
        run_len(1, n);
        chk("t2_g13_len", n, 10);
        chk("t2_yellow", int'(phase), 2);
        step();
        step();
        chk("t2_ar", int'(phase), 6);
        step();
        chk("t2_reenter", int'(phase), 1);
        traffic = 4'b0000;
        repeat (20) step();
        chk("t2_idle", int'(phase), 0);
        // saturated demand rotates through all three groups
        do_reset();
        traffic = 4'b1111;
        ped = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            hist[i] = int'(phase);
        end
        for (int i = 0; i < 60; i++)
            if (hist[i] inside {1, 3, 5} && (i == 0 || hist[i] != hist[i-1])) gl.push_back(hist[i]);
        for (int k = 0; k < 4; k++) chk("t3_order", k < gl.size() ? gl[k] : -1, ord[k]);
        n = 0;
        for (int i = 0; i < 20; i++) if (hist[i] == 1) n++;
        chk("t3_g13_len", n, 4);
        n = 0;
        for (int i = 0; i < 20; i++) if (hist[i] == 3) n++;
        chk("t3_g24_len", n, 4);
        n = 0;
        for (int i = 0; i < 20; i++) if (hist[i] == 5) n++;
        chk("t3_walk_len", n, 5);
        traffic = 4'b0000;
        ped = 1'b0;
        repeat (40) step();
        // competing request blocks extension
        do_reset();
        traffic = 4'b0001;
        step();
        step();
        traffic = 4'b0011;
        step();
        traffic = 4'b0001;
        step();
        chk("t4_age4", int'(phase), 1);
        step();
        chk("t4_yellow", int'(phase), 2);
        step();
        step();
        chk("t4_ar", int'(phase), 6);
        step();
        chk("t4_g24", int'(phase), 3);
        traffic = 4'b0000;
        repeat (30) step();
        // pedestrian pulse during G24
        do_reset();
        traffic = 4'b1010;
        step();
        chk("t5_g24", int'(phase), 3);
        ped = 1'b1;
        step();
        ped = 1'b0;
        step();
        step();
        chk("t5_g24_c4", int'(phase), 3);
        step();
        chk("t5_y24", int'(phase), 4);
        step();
        step();
        chk("t5_ar", int'(phase), 6);
        step();
        chk("t5_ped", int'(phase), 5);
        chk("t5_walk", int'(walk), 1);
        chk("t5_red", int'(red), 15);
        run_len(5, n);
        chk("t5_walk_len", n, 5);
        traffic = 4'b0000;
        repeat (30) step();
        // reset during yellow
        do_reset();
        traffic = 4'b1010;
        step();
        traffic = 4'b0000;
        repeat (3) step();
        step();
        chk("t6_y24", int'(phase), 4);
        rst = 1'b1;
        step();
        chk("t6_rst_phase", int'(phase), 0);
        chk("t6_rst_red", int'(red), 15);
        rst = 1'b0;
        repeat (10) step();
        chk("t6_stay_idle", int'(phase), 0);
        // mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) traffic = 4'($urandom_range(0, 15));
            ped = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Round-robin phase scheduler for the four-approach intersection. It latches vehicle requests (approach pairs 1/3 and 2/4) and a pedestrian request, and grants the intersection to one requester at a time with fair rotation. Green time is actuated: minimum, extension and maximum. Every phase change passes through yellow and all-red clearance. It drives the lamp vectors and walk signal directly and replaces the fixed two-group sequencing for sites that have pedestrian crossings.

## Interface
- GREEN_MIN, 4: green length in cycles before any extension; ≥1.
- GREEN_MAX, 10: maximum total green length in cycles; ≥ GREEN_MIN.
- EXT_TIME, 3: cycles added per green extension; ≥1.
- YELLOW_TIME, 2: yellow length in cycles; ≥1.
- ALLRED_TIME, 1: all-red clearance length in cycles; ≥1.
- WALK_TIME, 5: walk phase length in cycles; ≥1.
- TIMER_W, 16: width of the phase timer and the green-age counter; must hold GREEN_MAX.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- Traffic  in  4  live vehicle presence per approach; bit i is approach i+1.
- Ped_req  in  1  pedestrian button; level or single-cycle pulse.
- Red, Yellow, Green  out  4 each  lamp vectors; bit i is approach i+1.
- Walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code, for debug.

## Operation
- States and codes: IDLE=0, G13=1, Y13=2, G24=3, Y24=4, PED=5, AR=6.
- Lamp outputs are decoded combinationally from the state register:
  - G13: Red=1010, Green=0101.
  - Y13: Red=1010, Yellow=0101.
  - G24: Red=0101, Green=1010.
  - Y24: Red=0101, Yellow=1010.
  - IDLE, AR, PED: Red=1111.
  - Walk=1 only in PED. Any lamp vector not listed for a state is 0000.
- Request latches req13, req24 and reqp:
  - req13 is set at an edge where Traffic[0]|Traffic[2]=1 and the state is not G13.
  - req24 and reqp follow the same rule with Traffic[1]|Traffic[3] / G24 and Ped_req / PED.
  - Each latch is cleared at the edge that enters its own green (or PED). Clear takes precedence over a simultaneous set.
- Pending requests use latch | live input: pend13, pend24 and pendp.
- Arbitration is round-robin on the pointer `last`, which records the last group served:
  - last=13: order is 24, P, 13.
  - last=24: order is P, 13, 24.
  - last=P: order is 13, 24, P.
  - Reset value is last=P.
  - `last` updates on entry to G13, G24 or PED.
- Arbitration is evaluated in IDLE every cycle and in the final cycle of AR. With a winner, the next state is that winner's G13, G24 or PED. With no winner, AR goes to IDLE and IDLE holds.
- Timer: loaded with N-1 on entry to a state whose duration is N; decrements each cycle. The state's final cycle is the one with timer==0, so each state lasts exactly N cycles.
- Green (G13/G24):
  - Loads GREEN_MIN-1 on entry.
  - `age` counts green cycles, starting at 1 in the first cycle.
  - At timer==0 the green extends (timer reloads EXT_TIME-1, state unchanged) only if all three hold:
    - the group's own live traffic is present;
    - no competing pend (the other group or pedestrian) is present;
    - age+EXT_TIME ≤ GREEN_MAX.
  - Otherwise the next state is Y13/Y24.
- Y13/Y24 → AR after YELLOW_TIME cycles. PED → AR after WALK_TIME cycles. AR arbitrates after ALLRED_TIME cycles.

## Timing
- Reset, applied at a clock edge, sets:
  - state=IDLE, timer=0, age=0, all latches=0, last=P;
  - outputs Red=1111, Yellow=0000, Green=0000, Walk=0, phase=0.
- Reset mid-phase aborts immediately without yellow; the lamps are all-red from the next cycle. Reset overrides every other event.
- Request latency from IDLE: an input high at edge k causes entry to the granted state at edge k. That state is visible for the whole cycle after edge k.
- A single-cycle Ped_req pulse is never lost unless it occurs while in PED. A pulse during PED is ignored because that request is being served.
- Requests that arrive in yellow, AR or PED are honoured at the next arbitration.
- GREEN_MIN=GREEN_MAX disables extension. Counters never wrap, because `age` is bounded by GREEN_MAX.

## Test plan
All tests use the default parameters.
- After reset, pulse Traffic=0001 for one cycle at edge k. Expected response:
  - G13 during cycles k+1..k+4;
  - Y13 during k+5..k+6;
  - AR during k+7;
  - IDLE from k+8 with Red=1111.
- Hold Traffic=0001 with nothing else. G13 lasts 10 cycles (4+3+3; a third extension would exceed 10), then Y13 and AR. G13 is then re-entered because req13 was latched during yellow.
- Hold Traffic=1111 and Ped_req=1 from IDLE. Grant order is G13, G24, PED, G13, ... Each green is exactly 4 cycles and Walk=1 for exactly 5 cycles, with Red=1111.
- Hold Traffic=0001 and pulse Traffic[1] at age 2 of G13. G13 ends at 4 cycles with no extension, then Y13, AR and G24 follow.
- Pulse Ped_req in the first cycle of G24 while Traffic=1010 is held. G24 ends at 4 cycles, then Y24 and AR, then PED with Walk=1 for 5 cycles.
- Assert rst for one edge during Y24 with all inputs low. Next cycle: phase=0 and Red=1111. No further grant occurs.
